// File: rtl/uat_txbuf.sv
// Transmit byte buffer: circular FIFO between the host and the UART transmit state machine.
// The head byte is registered into tx_byte on each accepted pop and held until the next one.
module uat_txbuf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_x,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          start_bit_sig,
    input  logic          clr_err,
    output logic          din_rdy,
    output logic [7:0]    tx_byte,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]  mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [7:0]    tx_byte_reg, tx_byte_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic full_w, empty_w, pop_ok, wr_ok;

    assign full_w  = (count_reg == DEPTH_C);
    assign empty_w = (count_reg == '0);
    assign pop_ok  = start_bit_sig && !empty_w;
    // A pop on the same edge frees the slot being written, so a full buffer still accepts.
    assign wr_ok   = wr_en && (!full_w || pop_ok);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        tx_byte_next   = tx_byte_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (wr_ok) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_next  = rd_ptr_reg + AW'(1);
            tx_byte_next = mem[rd_ptr_reg];
        end
        if (wr_ok && !pop_ok) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (pop_ok && !wr_ok) begin
            count_next = count_reg - (AW+1)'(1);
        end

        // Set takes priority over clear so a coincident error is never lost.
        if (clr_err) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (wr_en && full_w && !pop_ok) begin
            overflow_next = 1'b1;
        end
        if (start_bit_sig && empty_w) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            tx_byte_reg   <= 8'h00;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            tx_byte_reg   <= tx_byte_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk_x) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign count     = count_reg;
    assign full      = full_w;
    assign empty     = empty_w;
    assign din_rdy   = !empty_w;
    assign tx_byte   = tx_byte_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_uat_txbuf.sv
// Directed bench for uat_txbuf: a vector table for single-cycle behaviour plus
// hand-written sequences for fill/drain, simultaneous ops at full and mid-cycle reset.
module tb_uat_txbuf;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk_x = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          start_bit_sig = 1'b0;
    logic          clr_err = 1'b0;
    logic          din_rdy;
    logic [7:0]    tx_byte;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    uat_txbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_x        (clk_x),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .start_bit_sig(start_bit_sig),
        .clr_err      (clr_err),
        .din_rdy      (din_rdy),
        .tx_byte      (tx_byte),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk_x = ~clk_x;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       p;
        logic       c;
        int         exp_count;
        logic [7:0] exp_tx;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic [7:0] tx,
                             input logic ovf, input logic udf);
        chk({tag, ".count"},     32'(count),     32'(c));
        chk({tag, ".full"},      32'(full),      32'(c == DEPTH));
        chk({tag, ".empty"},     32'(empty),     32'(c == 0));
        chk({tag, ".din_rdy"},   32'(din_rdy),   32'(c != 0));
        chk({tag, ".tx_byte"},   32'(tx_byte),   32'(tx));
        chk({tag, ".overflow"},  32'(overflow),  32'(ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(udf));
        $display("%s: count=%0d tx_byte=%02h ovf=%0b udf=%0b", tag, count, tx_byte, overflow, underflow);
    endtask

    // Drive one cycle of inputs on the falling edge; sample 1 ns after the rising edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic p, input logic c);
        @(negedge clk_x);
        wr_en = w; wr_data = d; start_bit_sig = p; clr_err = c;
        @(posedge clk_x);
        #1;
        wr_en = 1'b0; start_bit_sig = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        //           w     d      p     c     cnt tx     ovf   udf
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 8'hA5, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 8'hA5, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3, 8'hA5, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h11, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 8'h11, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h22, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h33, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h33, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h33, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h5C, 1'b1, 1'b0, 1, 8'h33, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h5C, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h5C, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h5C, 1'b0, 1'b0};

        // Reset state, with clocks running under reset
        repeat (2) @(posedge clk_x);
        #1;
        check_all("reset", 0, 8'h00, 1'b0, 1'b0);
        @(negedge clk_x);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].w, vecs[i].d, vecs[i].p, vecs[i].c);
            check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tx,
                      vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // Three bytes popped 10 cycles apart, each held between pulses
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_b;
            exp_b = 8'(8'h11 * (i + 1));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check_all($sformatf("spaced_pop%0d", i), 2 - i, exp_b, 1'b0, 1'b0);
            repeat (9) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("spaced_hold%0d", i), 32'(tx_byte), 32'(exp_b));
        end

        // Fill, overflow with 8'hFF, drain across the pointer wrap
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
        end
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        check_all("overflow", DEPTH, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check_all($sformatf("drain%0d", i), DEPTH - 1 - i, 8'(8'h80 + i), 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_all("clr_ovf", 0, 8'h87, 1'b0, 1'b0);

        // Write and pop together at full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        check_all("full_wr_pop", DEPTH, 8'h40, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        check_all("ovf_set_wins", DEPTH, 8'h40, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == DEPTH - 1) ? 8'h99 : 8'(8'h41 + i);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check_all($sformatf("drain2_%0d", i), DEPTH - 1 - i, exp_b, 1'b0, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_all("udf_empty", 0, 8'h99, 1'b0, 1'b1);

        // Reset asserted between edges with bytes buffered
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        check_all("pre_reset", 4, 8'h99, 1'b0, 1'b1);
        @(negedge clk_x);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk_x);
        @(negedge clk_x);
        rst_n = 1'b1;
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        check_all("post_reset_wr", 1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_all("post_reset_pop", 0, 8'h77, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
